// File: rtl/mem_arbiter.sv
// Core/loader arbiter onto one fixed-latency memory port: one access in flight,
// round-robin on simultaneous requests, every output driven from a register.
module mem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_done,
    output logic [31:0] c_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        last_d_r, last_d_s;
    logic        own_d_r, own_d_s;
    logic        we_r, we_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] wdata_r, wdata_s;
    logic        grant_d_s, first_wr_s, capture_s;
    logic        m_en_r, m_we_r, c_done_r, d_done_r, busy_r;
    logic [31:0] m_addr_r, m_wdata_r, c_rdata_r, d_rdata_r;

    // On a tie the port that was not granted last wins
    assign grant_d_s = d_req & (~c_req | ~last_d_r);
    assign capture_s = (state_r == ACCESS) && (cnt_r == 4'd0) && !we_r;

    // Next-state, latch and arbitration-pointer logic
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        last_d_s   = last_d_r;
        own_d_s    = own_d_r;
        we_s       = we_r;
        addr_s     = addr_r;
        wdata_s    = wdata_r;
        first_wr_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (c_req || d_req) begin
                    state_s    = ACCESS;
                    cnt_s      = CNT_LOAD;
                    own_d_s    = grant_d_s;
                    we_s       = grant_d_s ? d_we    : c_we;
                    addr_s     = grant_d_s ? d_addr  : c_addr;
                    wdata_s    = grant_d_s ? d_wdata : c_wdata;
                    first_wr_s = grant_d_s ? d_we    : c_we;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == 4'd0) begin
                    state_s  = RESP;
                    last_d_s = own_d_r;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and latched request fields
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            last_d_r <= 1'b1;
            own_d_r  <= 1'b0;
            we_r     <= 1'b0;
            addr_r   <= 32'd0;
            wdata_r  <= 32'd0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            last_d_r <= last_d_s;
            own_d_r  <= own_d_s;
            we_r     <= we_s;
            addr_r   <= addr_s;
            wdata_r  <= wdata_s;
        end
    end

    // Outputs registered from the next state so they align with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            m_en_r    <= 1'b0;
            m_we_r    <= 1'b0;
            m_addr_r  <= 32'd0;
            m_wdata_r <= 32'd0;
            c_done_r  <= 1'b0;
            d_done_r  <= 1'b0;
            busy_r    <= 1'b0;
            c_rdata_r <= 32'd0;
            d_rdata_r <= 32'd0;
        end else begin
            m_en_r    <= (state_s == ACCESS);
            m_we_r    <= first_wr_s;
            m_addr_r  <= (state_s == ACCESS) ? addr_s  : 32'd0;
            m_wdata_r <= (state_s == ACCESS) ? wdata_s : 32'd0;
            c_done_r  <= (state_s == RESP) && !own_d_s;
            d_done_r  <= (state_s == RESP) && own_d_s;
            busy_r    <= (state_s != IDLE);
            c_rdata_r <= (capture_s && !own_d_r) ? m_rdata : c_rdata_r;
            d_rdata_r <= (capture_s && own_d_r)  ? m_rdata : d_rdata_r;
        end
    end

    assign m_en    = m_en_r;
    assign m_we    = m_we_r;
    assign m_addr  = m_addr_r;
    assign m_wdata = m_wdata_r;
    assign c_done  = c_done_r;
    assign d_done  = d_done_r;
    assign busy    = busy_r;
    assign c_rdata = c_rdata_r;
    assign d_rdata = d_rdata_r;

endmodule
